// File: rtl/vram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vram_port_arbiter: two-master arbiter for display RAM port A.            |
// | VRAM_ARB_RR_EN selects round-robin; otherwise fixed priority + guard.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_ack,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_ack,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    ram_we,
  output logic [DATA_WIDTH/8-1:0] ram_sel,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_d,
  input  logic [DATA_WIDTH-1:0]   ram_q,
  output logic                    busy,
  output logic                    grant_id
);

  localparam int c_sel_w = DATA_WIDTH / 8;
  localparam int c_cnt_w = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [c_sel_w-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    gid_q, gid_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic                    win_m1;

`ifdef VRAM_ARB_RR_EN
  logic                    rr_q, rr_d;
`else
  localparam int c_starve_w = $clog2(STARVE_MAX + 1);
  localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_MAX);
  logic [c_starve_w-1:0]   starve_q, starve_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gid_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef VRAM_ARB_RR_EN
      rr_q     <= 1'b1;
`else
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gid_q    <= gid_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef VRAM_ARB_RR_EN
      rr_q     <= rr_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gid_d    = gid_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef VRAM_ARB_RR_EN
    rr_d     = rr_q;
    win_m1   = (m0_req && m1_req) ? ~rr_q : m1_req;
`else
    starve_d = starve_q;
    win_m1   = (m0_req && m1_req) ? (starve_q == c_starve_lim) : m1_req;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_ISSUE;
          gid_d   = win_m1;
          we_d    = win_m1 ? m1_we    : m0_we;
          sel_d   = win_m1 ? m1_sel   : m0_sel;
          addr_d  = win_m1 ? m1_addr  : m0_addr;
          wdata_d = win_m1 ? m1_wdata : m0_wdata;
`ifdef VRAM_ARB_RR_EN
          rr_d    = win_m1;
`endif
        end
`ifndef VRAM_ARB_RR_EN
        // m1_req=1 guarantees a grant this cycle, so win_m1=0 means m0 got it
        if (!m1_req || win_m1) begin
          starve_d = '0;
        end else if (starve_q != c_starve_lim) begin
          starve_d = starve_q + c_starve_w'(1);
        end
`endif
      end
      S_ISSUE: begin
        state_d = we_q ? S_DONE : S_WAIT;
        cnt_d   = c_cnt_w'(READ_LAT);
      end
      S_WAIT: begin
        if (cnt_q == c_cnt_w'(1)) begin
          state_d = S_DONE;
          if (gid_q) rdata1_d = ram_q;
          else       rdata0_d = ram_q;
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_we   = (state_q == S_ISSUE) && we_q;
  assign ram_sel  = sel_q;
  assign ram_addr = addr_q;
  assign ram_d    = wdata_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = gid_q;
  assign m0_ack   = (state_q == S_DONE) && !gid_q;
  assign m1_ack   = (state_q == S_DONE) && gid_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule
`default_nettype wire

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single read/write port A of the byte-laned display RAM between two requesters.
- Master 0 is the CPU data path. Master 1 is the frame-fill/DMA engine.
- Serialises transactions, drives the RAM's we/sel/addr/d, waits out the BRAM read latency, and returns read data with a one-cycle ack per transaction.
- The display read port (port B) is untouched.

Parameters:
- ADDR_WIDTH, 10, word address width of the RAM.
- DATA_WIDTH, 32, data width; sel is DATA_WIDTH/8 bits (4 by default).
- READ_LAT, 1, RAM port-A read latency in cycles (≥1).
- STARVE_MAX, 4, max consecutive m0 grants while m1 waits (fixed-priority mode only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- m0_req  in  1  master 0 request; hold with command until m0_ack.
- m0_we  in  1  1=write, 0=read.
- m0_sel  in  4  byte-lane select.
- m0_addr  in  ADDR_WIDTH  word address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_WIDTH  read data; valid with m0_ack, held until the next m0 read completes.
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*, for master 1.
- ram_we  out  1  to RAM we.
- ram_sel  out  4  to RAM sel.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_d  out  DATA_WIDTH  to RAM d.
- ram_q  in  DATA_WIDTH  from RAM q.
- busy  out  1  1 when FSM ≠ IDLE.
- grant_id  out  1  master owning the current/last transaction.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - All outputs 0: ram_we, ram_sel, ram_addr, ram_d, m0_ack, m1_ack, m0_rdata, m1_rdata, busy, grant_id.
  - Starvation counter 0. RR pointer = 1.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE. If any req=1, pick a winner.
  - Register the winner's we/sel/addr/wdata and set grant_id, then go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE (1 cycle):
  - ram_addr/ram_sel/ram_d come from the registered command.
  - ram_we = registered we. ram_we is 0 in every other state.
  - Write → DONE. Read → WAIT with wait counter = READ_LAT.
- WAIT:
  - ram_addr/ram_sel are held.
  - The counter decrements each cycle.
  - On the cycle the counter hits 1, ram_q is captured into the granted master's rdata at that clock edge, then → DONE.
- DONE (1 cycle): ack of grant_id = 1, then → IDLE.
- Latency, with request seen in IDLE at cycle T:
  - Write: RAM written at the edge ending T+1; ack at T+2.
  - Read: ack at T+2+READ_LAT (T+3 at default).
- Minimum spacing: a master must deassert req in its ack cycle or a new transaction starts. Back-to-back throughput is one write per 3 cycles.
- Port hold: ram_addr/ram_sel/ram_d hold their last value in IDLE. Only ram_we is forced to 0.
- Arbitration, default (fixed priority + starvation guard):
  - m0 wins a tie unless starve_cnt == STARVE_MAX, in which case m1 wins.
  - starve_cnt increments (saturating) on each m0 grant made while m1_req=1.
  - starve_cnt clears on an m1 grant, or in IDLE when m1_req=0.
- Single requester: always granted, regardless of the counter.
- Request changes after grant: dropping req or changing the command after grant has no effect. The transaction completes and ack still pulses.
- Zero lanes: sel=0 write still issues ram_we=1 (no lanes change in the RAM) and acks normally.
- The other master's rdata is never modified by a transaction.
- Reset mid-transaction:
  - Immediate return to IDLE, ram_we=0, no ack.
  - rdata cleared; the aborted command is discarded.

Optional Feature:
- Macro: VRAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On a tie, grant the master not granted last.
  - Pointer = last grant_id; reset value 1, so m0 wins the first tie.
  - starve_cnt and STARVE_MAX are unused and not synthesised.
- Undefined: fixed priority + starvation guard as in Behaviour.

Test Plan:
1. Write, then read:
   - m0 write addr=0x005, sel=1111, wdata=0xDEADBEEF at T → ram_we=1 only at T+1, ram_addr=0x005, m0_ack at T+2.
   - m0 read addr=0x005 → m0_ack at T'+3, m0_rdata=0xDEADBEEF, m1_ack stays 0.
2. Byte-lane write:
   - m1 write addr=0x3FF, sel=0100, wdata=0x000000AB → ram_sel=0100, ram_d=0x000000AB in ISSUE, m1_ack at T+2, grant_id=1.
3. Tie, fixed mode:
   - m0_req and m1_req held continuously, each re-requesting after its ack → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1 with STARVE_MAX=4.
4. Tie, VRAM_ARB_RR_EN defined: same stimulus → grants alternate m0,m1,m0,m1.
5. Reset abort:
   - m0 read in WAIT (READ_LAT=3), assert rst asynchronously mid-cycle → ram_we=0, busy=0, m0_rdata=0 immediately.
   - No m0_ack after release. A new request is served normally.
6. Request dropped after grant:
   - m1 write granted at T, m1_req dropped at T+1 → write still performed, m1_ack at T+2.
   - Pending m0_req is granted at T+3.
